uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer among `NUM_REQ` parallel-word requesters. It accepts one word at a time from the granted requester and drives the `tx_start`/`tx_data` side of `uart_tx`. It then tracks `uart_tx`'s `tx_ready` through a complete frame before granting again. It sits between the on-chip producers (debug console, status reporter, etc.) and the single UART TX pin.

## Interface
- `NUM_REQ`, 4: number of requesters; at least 2.
- `WORD_LENGTH`, 8: word width; must match `uart_tx`.
- `ID_W`, `$clog2(NUM_REQ)`: grant index width (derived localparam).
- `clk` in 1: single clock, shared with `uart_tx`.
- `rst` in 1: synchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester word-pending flag.
- `req_data` in `NUM_REQ*WORD_LENGTH`: packed words; requester i occupies `[i*WORD_LENGTH +: WORD_LENGTH]`.
- `req_ready` out `NUM_REQ`: one-cycle accept pulse to the granted requester.
- `tx_start` out 1: start request to `uart_tx`.
- `tx_data` out `WORD_LENGTH`: word to `uart_tx`.
- `tx_ready` in 1: `uart_tx` idle flag; high means the serializer is idle.
- `grant_id` out `ID_W`: index of the current or last granted requester.
- `busy` out 1: high from grant until frame completion.

## Operation
- FSM states and transitions:
  - IDLE: when `tx_ready`=1 and any `req_valid` is set, grant and go to LAUNCH (or TAG_LAUNCH when tagging is enabled).
  - LAUNCH: hold `tx_start`=1 with the payload on `tx_data`. When `tx_ready`=0 is sampled, clear `tx_start` and go to WAIT_DONE.
  - WAIT_DONE: when `tx_ready`=1 is sampled, go to IDLE, clear `busy`, and set `rr_ptr` to (`grant_id`+1) mod `NUM_REQ`.
- Arbitration:
  - Search `req_valid` starting at `rr_ptr` and moving upward, wrapping at `NUM_REQ`-1. The first set bit wins.
  - `rr_ptr` resets to 0.
  - `rr_ptr` advances only after frame completion, never at grant time.
- Grant edge: capture the winner's word into a hold register, then set `grant_id`, `busy`=1, `req_ready[winner]`=1, and `tx_start`=1.
- `req_ready` is cleared on the next edge, so it is exactly one cycle wide.
- Requesters must hold `req_valid` and `req_data` stable until they see `req_ready`.
- `req_valid` still high in the `req_ready` cycle is not a new request. A new request is recognised only in IDLE.
- `tx_start` is held until `uart_tx` acknowledges by dropping `tx_ready`. This is required because `uart_tx` samples `tx_start` only on baud ticks.
- Guard: no grant while `tx_ready`=0 in IDLE. This covers `uart_tx` still finishing a frame after a controller reset.
- A `req_valid` deasserted by a non-granted requester before its turn is simply skipped.
- Reset values (`rst`=0 at an edge): state IDLE, `rr_ptr` 0, `tx_start` 0, `tx_data` 0, `req_ready` 0, `grant_id` 0, `busy` 0.
- Reset mid-frame: the word in flight is abandoned by the arbiter. `uart_tx` is not aborted. The next grant waits for `tx_ready`=1.

## Timing
- Request visible in cycle n with the arbiter in IDLE and `tx_ready`=1:
  - `req_ready` and `tx_start` are high in cycle n+1.
  - `tx_data` is valid from cycle n+1 and held until frame completion.
- `tx_ready` low sampled at edge k: `tx_start` is low from cycle k+1.
- `tx_ready` high sampled at edge m: the arbiter is in IDLE in cycle m+1, and the next grant occurs at edge m+1 at the earliest.
- Back-to-back overhead: one idle cycle per frame, plus the `uart_tx` baud-tick wait.

## Configuration
- `UART_ARB_TAG_EN` defined: each grant sends a tag word before the payload.
  - Tag word = MSB 1, bits `[ID_W-1:0]` = `grant_id`, all other bits 0.
  - Tag path: TAG_LAUNCH → TAG_WAIT_DONE → LAUNCH. The payload is held in the hold register.
  - `req_ready` still pulses at grant time.
  - `busy` spans both frames.
  - Requires `ID_W` ≤ `WORD_LENGTH`-1; violating this is an elaboration error.
- `UART_ARB_TAG_EN` not defined: tag states are absent, and one frame is sent per grant.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, TAG_LAUNCH, TAG_WAIT_DONE, LAUNCH, WAIT_DONE);
  - the tag-marker constant;
  - the default `WORD_LENGTH`.
- Sub-module `rr_picker`: combinational round-robin search. Inputs are `req_valid` and `rr_ptr`; outputs are `winner` index and `any_valid`.
- The FSM, hold register and pointer live in the top module.

## Test plan
- Single requester: `req_valid`=4'b0010 with word 0xA5; `uart_tx` model drops `tx_ready` 10 cycles later and raises it 100 cycles after that.
  - `req_ready`=4'b0010 for one cycle; `tx_data`=0xA5; `grant_id`=1.
  - `tx_start` falls one cycle after `tx_ready` falls; `busy` clears one cycle after `tx_ready` rises.
- Fairness: all four requesters held valid for 8 frames. Required grant order is 0,1,2,3,0,1,2,3.
- Skip: `req_valid`=4'b1001 with `rr_ptr`=1. Required order is 3 then 0.
- Busy guard: `tx_ready`=0 with `req_valid`=4'b0001 for 50 cycles. Required: no `req_ready` and no `tx_start` until `tx_ready`=1.
- Reset mid-frame: assert `rst`=0 during WAIT_DONE, release it with `tx_ready` still 0. Required: all outputs at reset values, and no grant until `tx_ready` rises.
- With `UART_ARB_TAG_EN`: requester 2 sends 0x3C. Required: two frames, 0x82 then 0x3C; `busy` stays high across both; a single `req_ready` pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// tag-word marker and the default word width.
package uart_pkg;

   localparam int DEFAULT_WORD_LENGTH = 8;

   // Value placed in the MSB of a tag word so the receiver can tell it from payload.
   localparam logic TAG_MARKER = 1'b1;

   typedef enum logic [2:0] {
      IDLE          = 3'd0,
      TAG_LAUNCH    = 3'd1,
      TAG_WAIT_DONE = 3'd2,
      LAUNCH        = 3'd3,
      WAIT_DONE     = 3'd4
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set req_valid bit at or above
// rr_ptr, wrapping at NUM_REQ-1.
module rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [ID_W-1:0]    winner,
   output logic               any_valid
);

   localparam int SUM_W = ID_W + 1;

   logic [SUM_W-1:0] sum_s;
   logic [ID_W-1:0]  idx_s;

   // Walk the requesters from rr_ptr upward; the first pending one wins.
   always_comb begin
      winner    = {ID_W{1'b0}};
      any_valid = 1'b0;
      sum_s     = {SUM_W{1'b0}};
      idx_s     = {ID_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         sum_s = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum_s >= SUM_W'(NUM_REQ)) begin
            sum_s = sum_s - SUM_W'(NUM_REQ);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[ID_W-1:0];
         if (!any_valid && req_valid[idx_s]) begin
            winner    = idx_s;
            any_valid = 1'b1;
         end else begin
            any_valid = any_valid;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among NUM_REQ requesters.
// Define UART_ARB_TAG_EN to prefix every granted word with a requester tag frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int  NUM_REQ     = 4,
   parameter int  WORD_LENGTH = DEFAULT_WORD_LENGTH,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           tx_start,
   output logic [WORD_LENGTH-1:0]         tx_data,
   input  logic                           tx_ready,
   output logic [ID_W-1:0]                grant_id,
   output logic                           busy
);

   if (NUM_REQ < 2) begin : g_num_req_err
      $error("uart_tx_arbiter: NUM_REQ must be at least 2");
   end

`ifdef UART_ARB_TAG_EN
   if (ID_W > WORD_LENGTH - 1) begin : g_tag_width_err
      $error("uart_tx_arbiter: grant index does not fit below the tag marker bit");
   end

   function automatic logic [WORD_LENGTH-1:0] make_tag(input logic [ID_W-1:0] id);
      logic [WORD_LENGTH-1:0] tag;
      tag                  = {WORD_LENGTH{1'b0}};
      tag[WORD_LENGTH-1]   = TAG_MARKER;
      tag[ID_W-1:0]        = id;
      return tag;
   endfunction
`endif

   arb_state_t             state_r;
   arb_state_t             next_state_s;
   logic [ID_W-1:0]        rr_ptr_r;
   logic [ID_W-1:0]        next_rr_ptr_s;
   logic [WORD_LENGTH-1:0] hold_r;
   logic [WORD_LENGTH-1:0] next_hold_s;
   logic                   next_tx_start_s;
   logic [WORD_LENGTH-1:0] next_tx_data_s;
   logic [NUM_REQ-1:0]     next_req_ready_s;
   logic [ID_W-1:0]        next_grant_s;
   logic                   next_busy_s;
   logic [ID_W-1:0]        winner_s;
   logic                   any_valid_s;
   logic [WORD_LENGTH-1:0] words_s [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words_s[g] = req_data[g*WORD_LENGTH +: WORD_LENGTH];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_r),
      .winner    (winner_s),
      .any_valid (any_valid_s)
   );

   // Next-state and next-output decode; every output keeps its value unless a transition changes it.
   always_comb begin
      next_state_s     = state_r;
      next_rr_ptr_s    = rr_ptr_r;
      next_hold_s      = hold_r;
      next_tx_start_s  = tx_start;
      next_tx_data_s   = tx_data;
      next_req_ready_s = {NUM_REQ{1'b0}};
      next_grant_s     = grant_id;
      next_busy_s      = busy;
      case (state_r)
         IDLE: begin
            // tx_ready low here means uart_tx is still draining a frame we no longer own.
            if (tx_ready && any_valid_s) begin
               next_hold_s                = words_s[winner_s];
               next_grant_s               = winner_s;
               next_busy_s                = 1'b1;
               next_req_ready_s[winner_s] = 1'b1;
               next_tx_start_s            = 1'b1;
`ifdef UART_ARB_TAG_EN
               next_tx_data_s             = make_tag(winner_s);
               next_state_s               = TAG_LAUNCH;
`else
               next_tx_data_s             = words_s[winner_s];
               next_state_s               = LAUNCH;
`endif
            end else begin
               next_state_s = IDLE;
            end
         end
`ifdef UART_ARB_TAG_EN
         TAG_LAUNCH: begin
            if (!tx_ready) begin
               next_tx_start_s = 1'b0;
               next_state_s    = TAG_WAIT_DONE;
            end else begin
               next_state_s = TAG_LAUNCH;
            end
         end
         TAG_WAIT_DONE: begin
            if (tx_ready) begin
               next_tx_start_s = 1'b1;
               next_tx_data_s  = hold_r;
               next_state_s    = LAUNCH;
            end else begin
               next_state_s = TAG_WAIT_DONE;
            end
         end
`endif
         LAUNCH: begin
            next_tx_data_s = hold_r;
            // uart_tx only samples tx_start on baud ticks, so hold it until acknowledged.
            if (!tx_ready) begin
               next_tx_start_s = 1'b0;
               next_state_s    = WAIT_DONE;
            end else begin
               next_state_s = LAUNCH;
            end
         end
         WAIT_DONE: begin
            if (tx_ready) begin
               next_busy_s  = 1'b0;
               next_state_s = IDLE;
               if (grant_id == ID_W'(NUM_REQ - 1)) begin
                  next_rr_ptr_s = {ID_W{1'b0}};
               end else begin
                  next_rr_ptr_s = grant_id + ID_W'(1);
               end
            end else begin
               next_state_s = WAIT_DONE;
            end
         end
         default: begin
            next_state_s    = IDLE;
            next_tx_start_s = 1'b0;
            next_busy_s     = 1'b0;
         end
      endcase
   end

   // State, pointer, hold word and all outputs registered with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         rr_ptr_r  <= {ID_W{1'b0}};
         hold_r    <= {WORD_LENGTH{1'b0}};
         tx_start  <= 1'b0;
         tx_data   <= {WORD_LENGTH{1'b0}};
         req_ready <= {NUM_REQ{1'b0}};
         grant_id  <= {ID_W{1'b0}};
         busy      <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         rr_ptr_r  <= next_rr_ptr_s;
         hold_r    <= next_hold_s;
         tx_start  <= next_tx_start_s;
         tx_data   <= next_tx_data_s;
         req_ready <= next_req_ready_s;
         grant_id  <= next_grant_s;
         busy      <= next_busy_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a cycle-stepped uart_tx model
// and queue-backed requesters; tag frames are expected when UART_ARB_TAG_EN is set.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int WL      = 8;
   localparam int ID_W    = 2;

   logic                   clk;
   logic                   rst;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*WL-1:0]  req_data;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   tx_start;
   logic [WL-1:0]          tx_data;
   logic                   tx_ready;
   logic [ID_W-1:0]        grant_id;
   logic                   busy;

   uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .WORD_LENGTH(WL)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   int            exp_id_q[$];
   logic [WL-1:0] exp_data_q[$];
   int            exp_busy_q[$];
   logic [WL-1:0] rq_q[NUM_REQ][$];

   int m_state    = 0;
   int m_cnt      = 0;
   int drop_dly   = 4;
   int high_dly   = 20;
   bit m_auto     = 1'b1;
   bit chk_start_low = 1'b0;
   int chk_busy   = -1;
   bit rr_prev    = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic request(input int i, input logic [WL-1:0] w);
      if (!req_valid[i]) begin
         req_data[i*WL +: WL] = w;
         req_valid[i]         = 1'b1;
      end else begin
         rq_q[i].push_back(w);
      end
   endtask

   task automatic expect_grant(input int id, input logic [WL-1:0] w, input int busy_after);
      exp_id_q.push_back(id);
`ifdef UART_ARB_TAG_EN
      begin
         logic [WL-1:0] tag;
         tag           = '0;
         tag[WL-1]     = 1'b1;
         tag[ID_W-1:0] = id[ID_W-1:0];
         exp_data_q.push_back(tag);
         exp_busy_q.push_back(1);
      end
`endif
      exp_data_q.push_back(w);
      exp_busy_q.push_back(busy_after);
   endtask

   // One clock cycle: sample at the falling edge, run requesters and the uart_tx model.
   task automatic tick();
      int id;
      @(negedge clk);
      if (rr_prev) begin
         check_eq("rdy_pulse", 32'(req_ready), 32'd0);
         rr_prev = 1'b0;
      end else if (req_ready != '0) begin
         if (exp_id_q.size() == 0) begin
            check_eq("rdy_unexpected", 32'(req_ready), 32'd0);
         end else begin
            id = exp_id_q.pop_front();
            check_eq("rdy_vec", 32'(req_ready), 32'd1 << id);
            check_eq("grant_id", 32'(grant_id), 32'(id));
            check_eq("busy_grant", 32'(busy), 32'd1);
         end
         rr_prev = 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
               if (rq_q[i].size() > 0) req_data[i*WL +: WL] = rq_q[i].pop_front();
               else req_valid[i] = 1'b0;
            end
         end
      end
      if (chk_start_low) begin
         check_eq("start_fall", 32'(tx_start), 32'd0);
         chk_start_low = 1'b0;
      end
      if (chk_busy >= 0) begin
         check_eq("busy_end", 32'(busy), 32'(chk_busy));
         chk_busy = -1;
      end
      case (m_state)
         0: if (m_auto && tx_start && tx_ready) begin
               m_state = 1;
               m_cnt   = drop_dly;
            end
         1: begin
            check_eq("start_hold", 32'(tx_start), 32'd1);
            if (m_cnt <= 1) begin
               tx_ready = 1'b0;
               if (exp_data_q.size() == 0) begin
                  check_eq("frame_unexpected", 32'(tx_data), 32'hFFFF_FFFF);
                  id = -1;
               end else begin
                  check_eq("tx_data", 32'(tx_data), 32'(exp_data_q.pop_front()));
                  id = exp_busy_q.pop_front();
               end
               m_cnt         = high_dly;
               m_state       = 2;
               chk_start_low = 1'b1;
               exp_busy_q.push_front(id);
            end else begin
               m_cnt--;
            end
         end
         2: if (m_cnt <= 1) begin
               tx_ready = 1'b1;
               m_state  = 0;
               chk_busy = exp_busy_q.pop_front();
            end else begin
               m_cnt--;
            end
         default: m_state = 0;
      endcase
   endtask

   task automatic drain(input string tag, input int max_cycles);
      int c;
      c = 0;
      while ((exp_data_q.size() != 0 || exp_id_q.size() != 0 || m_state != 0 ||
              busy || chk_busy >= 0) && c < max_cycles) begin
         tick();
         c++;
      end
      check_eq(tag, 32'(exp_data_q.size() + exp_id_q.size() + m_state), 32'd0);
   endtask

   initial begin
      logic [WL-1:0] w;
      rst       = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_ready  = 1'b1;
      repeat (3) tick();
      check_eq("rst_tx_start", 32'(tx_start), 32'd0);
      check_eq("rst_tx_data", 32'(tx_data), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      check_eq("rst_grant_id", 32'(grant_id), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;

      // Fairness: everyone always pending, two words each.
      drop_dly = 4;
      high_dly = 20;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            w = 8'(8'h40 + r * 4 + i);
            request(i, w);
            expect_grant(i, w, 0);
         end
      end
      drain("fair_drain", 5000);

      // Busy guard: serializer reports busy, nothing may be granted.
      m_auto   = 1'b0;
      tx_ready = 1'b0;
      request(0, 8'h77);
      expect_grant(0, 8'h77, 0);
      for (int c = 0; c < 50; c++) begin
         tick();
         check_eq("guard_start", 32'(tx_start), 32'd0);
         check_eq("guard_rdy", 32'(req_ready), 32'd0);
      end
      tx_ready = 1'b1;
      m_auto   = 1'b1;
      drain("guard_drain", 2000);

      // Skip: rr_ptr is now 1, requesters 0 and 3 pending.
      request(0, 8'hC0);
      request(3, 8'hC3);
      expect_grant(3, 8'hC3, 0);
      expect_grant(0, 8'hC0, 0);
      drain("skip_drain", 2000);

      // Single requester with slow serializer.
      drop_dly = 10;
      high_dly = 100;
      request(1, 8'hA5);
      expect_grant(1, 8'hA5, 0);
      drain("single_drain", 2000);

      // Reset during WAIT_DONE; the serializer keeps going.
      drop_dly = 3;
      high_dly = 60;
      request(1, 8'h5A);
      expect_grant(1, 8'h5A, -1);
      for (int c = 0; c < 100 && m_state != 2; c++) tick();
      check_eq("mf_reach_wait", 32'(m_state), 32'd2);
      repeat (5) tick();
      rst = 1'b0;
      tick();
      tick();
      check_eq("mf_tx_start", 32'(tx_start), 32'd0);
      check_eq("mf_tx_data", 32'(tx_data), 32'd0);
      check_eq("mf_req_ready", 32'(req_ready), 32'd0);
      check_eq("mf_grant_id", 32'(grant_id), 32'd0);
      check_eq("mf_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      request(0, 8'h11);
      expect_grant(0, 8'h11, 0);
      for (int c = 0; c < 200 && tx_ready == 1'b0; c++) begin
         tick();
         check_eq("mf_guard_start", 32'(tx_start), 32'd0);
         check_eq("mf_guard_rdy", 32'(req_ready), 32'd0);
      end
      drain("mf_drain", 2000);

`ifdef UART_ARB_TAG_EN
      // Tagged grant: 0x82 then 0x3C under one busy window.
      drop_dly = 4;
      high_dly = 20;
      request(2, 8'h3C);
      expect_grant(2, 8'h3C, 0);
      drain("tag_drain", 2000);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
